// File: rtl/nv_nvdla_qchannel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nv_nvdla_qchannel_ctrl
// Description : Q-channel low-power controller with channel gating, drain,
//               quiet period, deny-on-timeout and abort-on-wake.
//               Optional qactive output: NVDLA_QCHANNEL_QACTIVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nv_nvdla_qchannel_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int IDLE_CYCLES  = 2,
    parameter int QUIET_CYCLES = 16,
    parameter int DENY_TIMEOUT = 0
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              qreqn,
    output logic              qacceptn,
    output logic              qdeny,
    input  logic              core_busy,
    input  logic [NUM_CH-1:0] ch_in_vld,
    output logic [NUM_CH-1:0] ch_in_rdy,
    output logic [NUM_CH-1:0] ch_out_vld,
    input  logic [NUM_CH-1:0] ch_out_rdy,
    output logic              gate_open,
    output logic [2:0]        state_o
`ifdef NVDLA_QCHANNEL_QACTIVE_EN
    ,
    output logic              qactive
`endif
);

    localparam logic [2:0]  c_STOP       = 3'd0;
    localparam logic [2:0]  c_RUN        = 3'd1;
    localparam logic [2:0]  c_DRAIN      = 3'd2;
    localparam logic [2:0]  c_QUIET      = 3'd3;
    localparam logic [2:0]  c_DENY       = 3'd4;
    localparam logic [7:0]  c_IDLE_LAST  = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0]  c_QUIET_LAST = 8'(QUIET_CYCLES - 1);
    localparam logic [15:0] c_TO_LAST    = 16'(DENY_TIMEOUT - 1);
    localparam logic        c_DENY_EN    = (DENY_TIMEOUT != 0);

    logic [2:0]  r_state;
    logic [7:0]  r_idle_cnt;
    logic [15:0] r_to_cnt;
    logic        r_qacceptn;
    logic        r_qdeny;
    logic        r_gate_open;

    logic [2:0]  w_next_state;
    logic [7:0]  w_next_idle;
    logic [15:0] w_next_to;
    logic [7:0]  w_idle_inc;
    logic [15:0] w_to_inc;

    assign w_idle_inc = (r_idle_cnt == 8'hFF)    ? r_idle_cnt : r_idle_cnt + 8'd1;
    assign w_to_inc   = (r_to_cnt   == 16'hFFFF) ? r_to_cnt   : r_to_cnt + 16'd1;

    // Counters clear on every transition except DRAIN<->QUIET, where to_cnt
    // carries the accumulated drain time across busy re-assertions.
    always_comb begin
        w_next_state = r_state;
        w_next_idle  = r_idle_cnt;
        w_next_to    = r_to_cnt;
        case (r_state)
            c_STOP: begin
                if (qreqn) w_next_state = c_RUN;
                w_next_idle = 8'd0;
                w_next_to   = 16'd0;
            end
            c_RUN: begin
                if (!qreqn && (ch_in_vld == '0)) w_next_state = c_DRAIN;
                w_next_idle = 8'd0;
                w_next_to   = 16'd0;
            end
            c_DRAIN: begin
                if (qreqn) begin
                    w_next_state = c_RUN;
                    w_next_idle  = 8'd0;
                    w_next_to    = 16'd0;
                end else if (!core_busy && (r_idle_cnt == c_IDLE_LAST)) begin
                    w_next_state = c_QUIET;
                    w_next_idle  = 8'd0;
                end else if (c_DENY_EN && (r_to_cnt == c_TO_LAST)) begin
                    w_next_state = c_DENY;
                    w_next_idle  = 8'd0;
                    w_next_to    = 16'd0;
                end else begin
                    w_next_idle = core_busy ? 8'd0 : w_idle_inc;
                    w_next_to   = w_to_inc;
                end
            end
            c_QUIET: begin
                if (qreqn) begin
                    w_next_state = c_RUN;
                    w_next_idle  = 8'd0;
                    w_next_to    = 16'd0;
                end else if (core_busy) begin
                    w_next_state = c_DRAIN;
                    w_next_idle  = 8'd0;
                end else if (r_idle_cnt == c_QUIET_LAST) begin
                    w_next_state = c_STOP;
                    w_next_idle  = 8'd0;
                    w_next_to    = 16'd0;
                end else begin
                    w_next_idle = w_idle_inc;
                end
            end
            c_DENY: begin
                if (qreqn) w_next_state = c_RUN;
                w_next_idle = 8'd0;
                w_next_to   = 16'd0;
            end
            default: begin
                w_next_state = c_STOP;
                w_next_idle  = 8'd0;
                w_next_to    = 16'd0;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state     <= c_STOP;
            r_idle_cnt  <= 8'd0;
            r_to_cnt    <= 16'd0;
            r_qacceptn  <= 1'b0;
            r_qdeny     <= 1'b0;
            r_gate_open <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_idle_cnt  <= w_next_idle;
            r_to_cnt    <= w_next_to;
            r_qacceptn  <= (w_next_state != c_STOP);
            r_qdeny     <= (w_next_state == c_DENY);
            r_gate_open <= (w_next_state == c_RUN) || (w_next_state == c_DENY);
        end
    end

    assign qacceptn   = r_qacceptn;
    assign qdeny      = r_qdeny;
    assign gate_open  = r_gate_open;
    assign state_o    = r_state;
    assign ch_out_vld = ch_in_vld  & {NUM_CH{r_gate_open}};
    assign ch_in_rdy  = ch_out_rdy & {NUM_CH{r_gate_open}};

`ifdef NVDLA_QCHANNEL_QACTIVE_EN
    // Wake hint for the power controller; the block never leaves STOP itself.
    logic r_qactive;
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) r_qactive <= 1'b0;
        else                r_qactive <= (|ch_in_vld) | core_busy;
    end
    assign qactive = r_qactive;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_qchannel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nv_nvdla_qchannel_ctrl
// Description : Scoreboard bench for nv_nvdla_qchannel_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_nvdla_qchannel_ctrl;

    localparam logic [2:0] c_STOP  = 3'd0;
    localparam logic [2:0] c_RUN   = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_QUIET = 3'd3;
    localparam logic [2:0] c_DENY  = 3'd4;

    logic       nvdla_core_clk = 1'b0;
    logic       nvdla_core_rst = 1'b1;
    logic       qreqn          = 1'b1;
    logic       qacceptn;
    logic       qdeny;
    logic       core_busy      = 1'b0;
    logic [3:0] ch_in_vld      = 4'b0000;
    logic [3:0] ch_in_rdy;
    logic [3:0] ch_out_vld;
    logic [3:0] ch_out_rdy     = 4'b1111;
    logic       gate_open;
    logic [2:0] state_o;
`ifdef NVDLA_QCHANNEL_QACTIVE_EN
    logic       qactive;
`endif

    int total = 0;
    int bad   = 0;
    logic [5:0] sb[$];
    logic [5:0] e;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    nv_nvdla_qchannel_ctrl #(
        .NUM_CH       (4),
        .IDLE_CYCLES  (2),
        .QUIET_CYCLES (16),
        .DENY_TIMEOUT (8)
    ) dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .qreqn          (qreqn),
        .qacceptn       (qacceptn),
        .qdeny          (qdeny),
        .core_busy      (core_busy),
        .ch_in_vld      (ch_in_vld),
        .ch_in_rdy      (ch_in_rdy),
        .ch_out_vld     (ch_out_vld),
        .ch_out_rdy     (ch_out_rdy),
        .gate_open      (gate_open),
        .state_o        (state_o)
`ifdef NVDLA_QCHANNEL_QACTIVE_EN
        ,
        .qactive        (qactive)
`endif
    );

    // Expected {state, qacceptn, qdeny, gate_open} for a given state.
    function automatic logic [5:0] exp_of(input logic [2:0] st);
        return {st, (st != c_STOP), (st == c_DENY), ((st == c_RUN) || (st == c_DENY))};
    endfunction

    task automatic tick();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic push_n(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) sb.push_back(exp_of(st));
    endtask

    task automatic test_reset();
        nvdla_core_rst = 1'b1; qreqn = 1'b1; ch_in_vld = 4'b1010; core_busy = 1'b0;
        push_n(c_STOP, 2);
        repeat (2) begin
            tick(); e = sb.pop_front(); total++;
            if ({state_o, qacceptn, qdeny, gate_open} !== e) begin
                bad++; $display("FAIL reset_state: got %b want %b", {state_o, qacceptn, qdeny, gate_open}, e);
            end
        end
        total++;
        if ({ch_out_vld, ch_in_rdy} !== 8'h00) begin
            bad++; $display("FAIL reset_chan: got %b want 00000000", {ch_out_vld, ch_in_rdy});
        end
        nvdla_core_rst = 1'b0;
        push_n(c_RUN, 1);
        tick(); e = sb.pop_front(); total++;
        if ({state_o, qacceptn, qdeny, gate_open} !== e) begin
            bad++; $display("FAIL reset_wake: got %b want %b", {state_o, qacceptn, qdeny, gate_open}, e);
        end
        total++;
        if ({ch_out_vld, ch_in_rdy} !== {4'b1010, 4'b1111}) begin
            bad++; $display("FAIL run_pass: got %b want 10101111", {ch_out_vld, ch_in_rdy});
        end
    endtask

    task automatic test_drain_accept();
        qreqn = 1'b0; ch_in_vld = 4'b0000; core_busy = 1'b0;
        push_n(c_DRAIN, 2); push_n(c_QUIET, 16); push_n(c_STOP, 1);
        repeat (19) begin
            tick(); e = sb.pop_front(); total++;
            if ({state_o, qacceptn, qdeny, gate_open} !== e) begin
                bad++; $display("FAIL drain_accept: got %b want %b", {state_o, qacceptn, qdeny, gate_open}, e);
            end
        end
        qreqn = 1'b1;
        push_n(c_RUN, 1);
        tick(); e = sb.pop_front(); total++;
        if ({state_o, qacceptn, qdeny, gate_open} !== e) begin
            bad++; $display("FAIL stop_wake: got %b want %b", {state_o, qacceptn, qdeny, gate_open}, e);
        end
    endtask

    task automatic test_hold_valid();
        qreqn = 1'b0; ch_in_vld = 4'b0001; core_busy = 1'b0;
        push_n(c_RUN, 5); push_n(c_DRAIN, 1); push_n(c_RUN, 1);
        for (int i = 0; i < 7; i++) begin
            if (i == 5) ch_in_vld = 4'b0000;
            if (i == 6) qreqn = 1'b1;
            tick(); e = sb.pop_front(); total++;
            if ({state_o, qacceptn, qdeny, gate_open} !== e) begin
                bad++; $display("FAIL hold_valid[%0d]: got %b want %b", i, {state_o, qacceptn, qdeny, gate_open}, e);
            end
            if (i == 4) begin
                total++;
                if (ch_out_vld !== 4'b0001) begin
                    bad++; $display("FAIL hold_pass: got %b want 0001", ch_out_vld);
                end
            end
        end
    endtask

    task automatic test_deny();
        qreqn = 1'b0; ch_in_vld = 4'b0000; core_busy = 1'b1;
        push_n(c_DRAIN, 8); push_n(c_DENY, 4); push_n(c_RUN, 1);
        for (int i = 0; i < 13; i++) begin
            if (i == 9) ch_in_vld = 4'b0110;
            if (i == 12) begin qreqn = 1'b1; core_busy = 1'b0; end
            tick(); e = sb.pop_front(); total++;
            if ({state_o, qacceptn, qdeny, gate_open} !== e) begin
                bad++; $display("FAIL deny[%0d]: got %b want %b", i, {state_o, qacceptn, qdeny, gate_open}, e);
            end
            if (i == 11) begin
                total++;
                if ({ch_out_vld, ch_in_rdy} !== {4'b0110, 4'b1111}) begin
                    bad++; $display("FAIL deny_pass: got %b want 01101111", {ch_out_vld, ch_in_rdy});
                end
            end
        end
        ch_in_vld = 4'b0000;
    endtask

    task automatic test_quiet_busy();
        qreqn = 1'b0; ch_in_vld = 4'b0000; core_busy = 1'b0;
        push_n(c_DRAIN, 2); push_n(c_QUIET, 5); push_n(c_DRAIN, 2);
        push_n(c_QUIET, 16); push_n(c_STOP, 1); push_n(c_RUN, 1);
        for (int i = 0; i < 27; i++) begin
            core_busy = (i == 7);
            if (i == 26) qreqn = 1'b1;
            tick(); e = sb.pop_front(); total++;
            if ({state_o, qacceptn, qdeny, gate_open} !== e) begin
                bad++; $display("FAIL quiet_busy[%0d]: got %b want %b", i, {state_o, qacceptn, qdeny, gate_open}, e);
            end
        end
        core_busy = 1'b0;
    endtask

    task automatic test_quiet_abort();
        qreqn = 1'b0;
        push_n(c_DRAIN, 2); push_n(c_QUIET, 3); push_n(c_RUN, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) qreqn = 1'b1;
            tick(); e = sb.pop_front(); total++;
            if ({state_o, qacceptn, qdeny, gate_open} !== e) begin
                bad++; $display("FAIL quiet_abort[%0d]: got %b want %b", i, {state_o, qacceptn, qdeny, gate_open}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        qreqn = 1'b0; ch_in_vld = 4'b0000; core_busy = 1'b0;
        push_n(c_DRAIN, 2); push_n(c_STOP, 2); push_n(c_RUN, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin nvdla_core_rst = 1'b1; qreqn = 1'b1; ch_in_vld = 4'b1111; end
            if (i == 3) begin nvdla_core_rst = 1'b0; qreqn = 1'b0; end
            if (i == 4) qreqn = 1'b1;
            tick(); e = sb.pop_front(); total++;
            if ({state_o, qacceptn, qdeny, gate_open} !== e) begin
                bad++; $display("FAIL reset_mid[%0d]: got %b want %b", i, {state_o, qacceptn, qdeny, gate_open}, e);
            end
            if (i == 2) begin
                total++;
                if ({ch_out_vld, ch_in_rdy, dut.r_idle_cnt, dut.r_to_cnt} !== 32'h0) begin
                    bad++; $display("FAIL reset_mid_clear: got vld=%b rdy=%b idle=%0d to=%0d want all 0",
                                    ch_out_vld, ch_in_rdy, dut.r_idle_cnt, dut.r_to_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_drain_accept();
        test_hold_valid();
        test_deny();
        test_quiet_busy();
        test_quiet_abort();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_left: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
